// File: rtl/counter_enable_gen.sv
// Programmable enable-pulse generator feeding the T input of the 4-bit counter stage.
// Divides clk by div+1 and runs continuously or for a fixed burst under start/stop control.
module counter_enable_gen #(
    parameter int DIV_WIDTH   = 8,
    parameter int BURST_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   mode,
    input  logic [DIV_WIDTH-1:0]   div,
    input  logic [BURST_WIDTH-1:0] burst_len,
    output logic                   T,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state, state_n;
    logic [DIV_WIDTH-1:0]   p, p_n;
    logic [DIV_WIDTH-1:0]   div_q, div_q_n;
    logic [BURST_WIDTH-1:0] rem, rem_n;
    logic                   mode_q, mode_q_n;
    logic                   t_n;
    logic                   done_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            p      <= '0;
            rem    <= '0;
            div_q  <= '0;
            mode_q <= 1'b0;
            T      <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            p      <= p_n;
            rem    <= rem_n;
            div_q  <= div_q_n;
            mode_q <= mode_q_n;
            T      <= t_n;
            done   <= done_n;
        end
    end

    // T and done are computed here but only reach the ports through registers.
    always_comb begin
        state_n  = state;
        p_n      = p;
        rem_n    = rem;
        div_q_n  = div_q;
        mode_q_n = mode_q;
        t_n      = 1'b0;
        done_n   = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    // An empty burst completes immediately without ever entering RUN.
                    if (mode && (burst_len == '0)) begin
                        done_n = 1'b1;
                    end else begin
                        state_n  = RUN;
                        p_n      = '0;
                        div_q_n  = div;
                        mode_q_n = mode;
                        rem_n    = burst_len;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                    p_n     = '0;
                end else if (p == div_q) begin
                    p_n = '0;
                    t_n = 1'b1;
                    if (mode_q) begin
                        rem_n = rem - BURST_WIDTH'(1);
                        if (rem == BURST_WIDTH'(1)) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end else begin
                    p_n = p + DIV_WIDTH'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_counter_enable_gen.sv
// Self-checking bench for counter_enable_gen: directed scenarios plus randomized traffic
// compared cycle by cycle against an elapsed-cycle reference model.
module tb_counter_enable_gen;

    localparam int DW = 8;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic          mode;
    logic [DW-1:0] div;
    logic [BW-1:0] burst_len;
    logic          T;
    logic          busy;
    logic          done;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: cycles since launch and pulses emitted, not a prescaler copy.
    bit m_run = 0;
    int m_k = 0;
    int m_emitted = 0;
    int m_div = 0;
    bit m_mode = 0;
    int m_len = 0;
    bit exp_t = 0;
    bit exp_done = 0;
    bit exp_busy = 0;

    int t_count = 0;
    logic [3:0] cnt_q = 4'd0;

    counter_enable_gen #(
        .DIV_WIDTH  (DW),
        .BURST_WIDTH(BW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .div      (div),
        .burst_len(burst_len),
        .T        (T),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelStep();
        exp_t    = 0;
        exp_done = 0;
        if (reset) begin
            m_run = 0;
        end else if (!m_run) begin
            if (start && !stop) begin
                if (mode && burst_len == 0) begin
                    exp_done = 1;
                end else begin
                    m_run     = 1;
                    m_k       = 0;
                    m_emitted = 0;
                    m_div     = int'(div);
                    m_mode    = mode;
                    m_len     = int'(burst_len);
                end
            end
        end else if (stop) begin
            m_run = 0;
        end else begin
            m_k++;
            if (m_k % (m_div + 1) == 0) begin
                exp_t = 1;
                if (m_mode) begin
                    m_emitted++;
                    if (m_emitted == m_len) begin
                        m_run    = 0;
                        exp_done = 1;
                    end
                end
            end
        end
        exp_busy = m_run;
    endtask

    // One clock cycle: drive on the falling edge, step the model, check just after the rising edge.
    task automatic applyStimulus(input bit r, input bit s, input bit sp, input bit m,
                                 input int d, input int bl);
        @(negedge clk);
        reset     = r;
        start     = s;
        stop      = sp;
        mode      = m;
        div       = DW'(d);
        burst_len = BW'(bl);
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("T", T, exp_t);
        checkOutput("busy", busy, exp_busy);
        checkOutput("done", done, exp_done);
        if (T) begin
            t_count++;
            cnt_q = cnt_q + 4'd1;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; start = 0; stop = 0; mode = 0; div = '0; burst_len = '0;

        // Reset held two cycles with start requested, then one cycle after release
        applyStimulus(1, 1, 0, 0, 3, 0);
        applyStimulus(1, 1, 0, 0, 3, 0);
        applyStimulus(0, 0, 0, 0, 3, 0);

        // Continuous, div=3: pulses after E4, E8, E12
        t_count = 0;
        cnt_q = 4'd0;
        applyStimulus(0, 1, 0, 0, 3, 0);
        idleCycles(12);
        checkOutput("cont_pulses", t_count, 3);
        checkOutput("counter_q", cnt_q, 3);
        applyStimulus(0, 0, 1, 0, 0, 0);
        idleCycles(2);

        // Burst div=1 len=3, then quiet
        t_count = 0;
        applyStimulus(0, 1, 0, 1, 1, 3);
        idleCycles(10);
        checkOutput("burst_pulses", t_count, 3);

        // Stop on the edge where the second pulse of div=2 is due
        t_count = 0;
        applyStimulus(0, 1, 0, 0, 2, 0);
        idleCycles(5);
        applyStimulus(0, 0, 1, 0, 0, 0);
        idleCycles(4);
        checkOutput("stop_pulses", t_count, 1);

        // div=0 continuous: every cycle
        t_count = 0;
        applyStimulus(0, 1, 0, 0, 0, 0);
        idleCycles(6);
        checkOutput("div0_pulses", t_count, 6);
        applyStimulus(0, 0, 1, 0, 0, 0);
        idleCycles(2);

        // Empty burst and start with stop in IDLE
        applyStimulus(0, 1, 0, 1, 2, 0);
        idleCycles(3);
        applyStimulus(0, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 1, 4);
        idleCycles(3);

        // Reset mid-burst, then a full 5-pulse burst
        applyStimulus(0, 1, 0, 1, 1, 5);
        idleCycles(4);
        applyStimulus(1, 0, 0, 0, 0, 0);
        idleCycles(2);
        t_count = 0;
        applyStimulus(0, 1, 0, 1, 1, 5);
        idleCycles(14);
        checkOutput("burst5_pulses", t_count, 5);

        // Back-to-back bursts with start held high
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 1, 2, 2);
        idleCycles(4);

        // Randomized traffic, mid-run input changes included
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 99) < 2),
                          ($urandom_range(0, 99) < 30),
                          ($urandom_range(0, 99) < 4),
                          $urandom_range(0, 1),
                          $urandom_range(0, 5),
                          $urandom_range(0, 7));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
